// File: rtl/hdmi_video_frontend.sv
// 720x480p60 raster generator and DVI TMDS encoder for the 27 MHz pixel domain.
// Coordinates lead the encoded symbols by two cycles; RGB is sampled one cycle after its coordinate.
module hdmi_video_frontend #(
    parameter int H_ACTIVE        = 720,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 62,
    parameter int H_BACK          = 60,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 9,
    parameter int V_SYNC          = 6,
    parameter int V_BACK          = 30,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               pixelClock,
    input  logic               reset,
    input  logic [7:0]         redByte,
    input  logic [7:0]         greenByte,
    input  logic [7:0]         blueByte,
    output logic signed [11:0] hPosCounter,
    output logic signed [10:0] vPosCounter,
    output logic               inActiveDisplay,
    output logic               hSync,
    output logic               vSync,
    output logic [9:0]         tmdsRed,
    output logic [9:0]         tmdsGreen,
    output logic [9:0]         tmdsBlue,
    output logic [9:0]         tmdsClock
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;

    localparam logic signed [11:0] H_FIRST   = 12'(-H_BLANK);
    localparam logic signed [11:0] H_LAST    = 12'(H_ACTIVE - 1);
    localparam logic signed [11:0] HS_FIRST  = 12'(H_FRONT - H_BLANK);
    localparam logic signed [11:0] HS_LAST   = 12'(H_FRONT + H_SYNC - 1 - H_BLANK);
    localparam logic signed [10:0] V_FIRST   = 11'(-V_BLANK);
    localparam logic signed [10:0] V_LAST    = 11'(V_ACTIVE - 1);
    localparam logic signed [10:0] VS_FIRST  = 11'(V_FRONT - V_BLANK);
    localparam logic signed [10:0] VS_LAST   = 11'(V_FRONT + V_SYNC - 1 - V_BLANK);
    localparam logic               SYNC_INV  = (SYNC_ACTIVE_LOW != 0);
    localparam logic [9:0]         CTRL_00   = 10'b1101010100;
    localparam logic [9:0]         CTRL_01   = 10'b0010101011;
    localparam logic [9:0]         CTRL_10   = 10'b0101010100;
    localparam logic [9:0]         CTRL_11   = 10'b1010101011;
    localparam logic [9:0]         CLK_SYM   = 10'b0000011111;

    function automatic logic [9:0] f_ctrl(input logic c1, input logic c0);
        logic [9:0] sym;
        case ({c1, c0})
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
        endcase
        return sym;
    endfunction

    // Returns {next_disparity[4:0], symbol[9:0]}.
    function automatic logic [14:0] f_encode(input logic [7:0] d, input logic signed [4:0] cnt);
        logic [3:0]        n1d;
        logic [3:0]        n1q;
        logic [3:0]        n0q;
        logic              use_xnor;
        logic [8:0]        qm;
        logic [9:0]        q;
        logic signed [4:0] diff;
        logic signed [4:0] nc;
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, d[i]};
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        n1q = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1q = n1q + {3'b000, qm[i]};
        end
        n0q  = 4'd8 - n1q;
        diff = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
        if ((cnt == 5'sd0) || (n1q == n0q)) begin
            q  = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            nc = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1q > n0q)) || ((cnt < 5'sd0) && (n0q > n1q))) begin
            q  = {1'b1, qm[8], ~qm[7:0]};
            nc = cnt + $signed({3'b000, qm[8], 1'b0}) - diff;
        end else begin
            q  = {1'b0, qm[8], qm[7:0]};
            nc = cnt - $signed({3'b000, ~qm[8], 1'b0}) + diff;
        end
        return {nc, q};
    endfunction

    logic signed [11:0] r_hPos;
    logic signed [10:0] r_vPos;
    logic               r_de;
    logic               r_hs;
    logic               r_vs;
    logic signed [11:0] w_hNext;
    logic signed [10:0] w_vNext;

    logic               r_de1;
    logic               r_hs1;
    logic               r_vs1;
    logic [7:0]         r_red1;
    logic [7:0]         r_green1;
    logic [7:0]         r_blue1;

    logic [9:0]         r_tmdsR;
    logic [9:0]         r_tmdsG;
    logic [9:0]         r_tmdsB;
    logic signed [4:0]  r_dispR;
    logic signed [4:0]  r_dispG;
    logic signed [4:0]  r_dispB;
    logic [14:0]        w_encR;
    logic [14:0]        w_encG;
    logic [14:0]        w_encB;

    always_comb begin
        w_hNext = r_hPos + 12'sd1;
        w_vNext = r_vPos;
        if (r_hPos == H_LAST) begin
            w_hNext = H_FIRST;
            w_vNext = (r_vPos == V_LAST) ? V_FIRST : (r_vPos + 11'sd1);
        end
    end

    assign w_encR = f_encode(r_red1, r_dispR);
    assign w_encG = f_encode(r_green1, r_dispG);
    assign w_encB = f_encode(r_blue1, r_dispB);

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            r_hPos   <= H_FIRST;
            r_vPos   <= V_FIRST;
            r_de     <= 1'b0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_de1    <= 1'b0;
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_red1   <= 8'd0;
            r_green1 <= 8'd0;
            r_blue1  <= 8'd0;
            r_tmdsR  <= CTRL_00;
            r_tmdsG  <= CTRL_00;
            r_tmdsB  <= CTRL_00;
            r_dispR  <= 5'sd0;
            r_dispG  <= 5'sd0;
            r_dispB  <= 5'sd0;
        end else begin
            r_hPos   <= w_hNext;
            r_vPos   <= w_vNext;
            r_de     <= !w_hNext[11] && !w_vNext[10];
            r_hs     <= (w_hNext >= HS_FIRST) && (w_hNext <= HS_LAST);
            r_vs     <= (w_vNext >= VS_FIRST) && (w_vNext <= VS_LAST);
            // Caller's RGB answers the previous coordinate, so DE/syncs are delayed to meet it.
            r_de1    <= r_de;
            r_hs1    <= r_hs;
            r_vs1    <= r_vs;
            r_red1   <= redByte;
            r_green1 <= greenByte;
            r_blue1  <= blueByte;
            if (r_de1) begin
                r_tmdsR <= w_encR[9:0];
                r_tmdsG <= w_encG[9:0];
                r_tmdsB <= w_encB[9:0];
                r_dispR <= w_encR[14:10];
                r_dispG <= w_encG[14:10];
                r_dispB <= w_encB[14:10];
            end else begin
                r_tmdsR <= CTRL_00;
                r_tmdsG <= CTRL_00;
                r_tmdsB <= f_ctrl(r_vs1 ^ SYNC_INV, r_hs1 ^ SYNC_INV);
                r_dispR <= 5'sd0;
                r_dispG <= 5'sd0;
                r_dispB <= 5'sd0;
            end
        end
    end

    assign hPosCounter     = r_hPos;
    assign vPosCounter     = r_vPos;
    assign inActiveDisplay = r_de;
    assign hSync           = r_hs;
    assign vSync           = r_vs;
    assign tmdsRed         = r_tmdsR;
    assign tmdsGreen       = r_tmdsG;
    assign tmdsBlue        = r_tmdsB;
    assign tmdsClock       = CLK_SYM;

endmodule

// File: tb/tb_hdmi_video_frontend.sv
// Bench for hdmi_video_frontend: full-size raster/encoder against a cycle-count model,
// plus a shrunken-timing instance to cover whole-frame wrap.
module tb_hdmi_video_frontend;

    localparam int HA = 720, HF = 16, HS = 62, HBK = 60, HBL = 138, HT = 858;
    localparam int VA = 480, VF = 9, VS = 6, VBK = 30, VBL = 45;
    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4, SHBL = 9;
    localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 3, SVBL = 6;
    localparam logic [9:0] C00 = 10'b1101010100;

    logic               clk;
    logic               rst;
    logic               rst_s;
    logic [7:0]         red, green, blue;
    logic signed [11:0] hpos, s_hpos;
    logic signed [10:0] vpos, s_vpos;
    logic               de, hs, vs, s_de, s_hs, s_vs;
    logic [9:0]         sym_r, sym_g, sym_b, sym_c;
    logic [9:0]         s_sym_r, s_sym_g, s_sym_b, s_sym_c;

    int n_checks = 0;
    int n_pass   = 0;
    int t;
    int ts;
    int disp_r, disp_g, disp_b;
    logic [9:0] q_r[$], q_g[$], q_b[$];
    logic [9:0] exp_r, exp_g, exp_b;

    hdmi_video_frontend dut (
        .pixelClock      (clk),
        .reset           (rst),
        .redByte         (red),
        .greenByte       (green),
        .blueByte        (blue),
        .hPosCounter     (hpos),
        .vPosCounter     (vpos),
        .inActiveDisplay (de),
        .hSync           (hs),
        .vSync           (vs),
        .tmdsRed         (sym_r),
        .tmdsGreen       (sym_g),
        .tmdsBlue        (sym_b),
        .tmdsClock       (sym_c)
    );

    hdmi_video_frontend #(
        .H_ACTIVE (SHA), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_ACTIVE (SVA), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .SYNC_ACTIVE_LOW (1)
    ) dut_small (
        .pixelClock      (clk),
        .reset           (rst_s),
        .redByte         (8'h00),
        .greenByte       (8'h00),
        .blueByte        (8'h00),
        .hPosCounter     (s_hpos),
        .vPosCounter     (s_vpos),
        .inActiveDisplay (s_de),
        .hSync           (s_hs),
        .vSync           (s_vs),
        .tmdsRed         (s_sym_r),
        .tmdsGreen       (s_sym_g),
        .tmdsBlue        (s_sym_b),
        .tmdsClock       (s_sym_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Position t cycles after reset release, from plain division of the cycle count.
    function automatic int m_h(int tt, int act, int blank);
        return (tt % (act + blank)) - blank;
    endfunction

    function automatic int m_v(int tt, int hact, int hblank, int vact, int vblank);
        return ((tt / (hact + hblank)) % (vact + vblank)) - vblank;
    endfunction

    function automatic logic m_sync(int pos, int blank, int front, int width);
        return (pos >= front - blank) && (pos < front - blank + width);
    endfunction

    function automatic logic [9:0] ref_ctrl(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic void ref_tmds(input logic [7:0] d, input int din, output logic [9:0] sym,
                                     output int dout);
        int ones_d, ones_q, zeros_q;
        logic use_xnor;
        logic [8:0] qm;
        ones_d   = $countones(d);
        use_xnor = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8]   = !use_xnor;
        ones_q  = $countones(qm[7:0]);
        zeros_q = 8 - ones_q;
        if (din == 0 || ones_q == zeros_q) begin
            sym  = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            dout = qm[8] ? din + ones_q - zeros_q : din + zeros_q - ones_q;
        end else if ((din > 0 && ones_q > zeros_q) || (din < 0 && zeros_q > ones_q)) begin
            sym  = {1'b1, qm[8], ~qm[7:0]};
            dout = din + (qm[8] ? 2 : 0) + zeros_q - ones_q;
        end else begin
            sym  = {1'b0, qm[8], qm[7:0]};
            dout = din - (qm[8] ? 0 : 2) + ones_q - zeros_q;
        end
    endfunction

    // Drive RGB for the current coordinate, predict its symbols two edges out, advance one edge.
    task automatic step_big();
        int h, v, sel;
        logic [23:0] rgb;
        logic [9:0] sr, sg, sb;
        h = m_h(t, HA, HBL);
        v = m_v(t, HA, HBL, VA, VBL);
        sel = $urandom_range(0, 3);
        if (v == 0 && h >= 0 && h <= 2) rgb = 24'h000000;
        else if (v == 1 && h == 0)      rgb = 24'hFFFFFF;
        else if (v == 2 && h == 0)      rgb = 24'h000000;
        else if (sel == 0)              rgb = 24'h000000;
        else if (sel == 1)              rgb = 24'hFFFFFF;
        else                            rgb = 24'($urandom);
        red   = rgb[23:16];
        green = rgb[15:8];
        blue  = rgb[7:0];
        if (h >= 0 && v >= 0) begin
            ref_tmds(rgb[23:16], disp_r, sr, disp_r);
            ref_tmds(rgb[15:8], disp_g, sg, disp_g);
            ref_tmds(rgb[7:0], disp_b, sb, disp_b);
        end else begin
            sr = C00;
            sg = C00;
            sb = ref_ctrl(!m_sync(v, VBL, VF, VS), !m_sync(h, HBL, HF, HS));
            disp_r = 0;
            disp_g = 0;
            disp_b = 0;
        end
        q_r.push_back(sr);
        q_g.push_back(sg);
        q_b.push_back(sb);
        @(posedge clk);
        #1;
        t++;
        exp_r = q_r.pop_front();
        exp_g = q_g.pop_front();
        exp_b = q_b.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({sym_r, sym_g, sym_b} !== {C00, C00, C00})
                $display("FAIL reset_symbols: got %b %b %b, expected %b x3", sym_r, sym_g, sym_b, C00);
            else n_pass++;
        end
        n_checks++;
        if ({hpos, vpos, de, hs, vs} !== {-12'sd138, -11'sd45, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_raster: got h=%0d v=%0d de=%b hs=%b vs=%b, expected -138 -45 0 0 0",
                     hpos, vpos, de, hs, vs);
        else n_pass++;
        n_checks++;
        if (sym_c !== 10'b0000011111)
            $display("FAIL clock_symbol: got %b, expected 0000011111", sym_c);
        else n_pass++;
        rst = 1'b0;
        t = 0;
        disp_r = 0;
        disp_g = 0;
        disp_b = 0;
        q_r = {C00};
        q_g = {C00};
        q_b = {10'b1010101011};
        step_big();
        n_checks++;
        if ({hpos, vpos} !== {-12'sd137, -11'sd45})
            $display("FAIL first_step: got h=%0d v=%0d, expected -137 -45", hpos, vpos);
        else n_pass++;
        n_checks++;
        if ({sym_r, sym_g, sym_b} !== {C00, C00, 10'b1010101011})
            $display("FAIL first_symbols: got %b %b %b, expected %b %b 1010101011",
                     sym_r, sym_g, sym_b, C00, C00);
        else n_pass++;
    endtask

    task automatic test_line_timing();
        int eh, ev, hs_cnt, first_hs, last_hs, ph;
        logic ede, ehs, evs;
        hs_cnt = 0;
        first_hs = 9999;
        last_hs = 9999;
        while (t < HT) begin
            step_big();
            eh = m_h(t, HA, HBL);
            ev = m_v(t, HA, HBL, VA, VBL);
            ede = (eh >= 0 && ev >= 0);
            ehs = m_sync(eh, HBL, HF, HS);
            evs = m_sync(ev, VBL, VF, VS);
            n_checks++;
            if ({hpos, vpos, de, hs, vs} !== {12'(eh), 11'(ev), ede, ehs, evs})
                $display("FAIL line_raster t=%0d: got h=%0d v=%0d de=%b hs=%b vs=%b, expected %0d %0d %b %b %b",
                         t, hpos, vpos, de, hs, vs, eh, ev, ede, ehs, evs);
            else n_pass++;
            n_checks++;
            if ({sym_r, sym_g, sym_b} !== {exp_r, exp_g, exp_b})
                $display("FAIL line_symbols t=%0d: got %h %h %h, expected %h %h %h",
                         t, sym_r, sym_g, sym_b, exp_r, exp_g, exp_b);
            else n_pass++;
            ph = m_h(t - 2, HA, HBL);
            if (ph == -100 || ph == -130) begin
                n_checks++;
                if ({sym_r, sym_g, sym_b} !== {C00, C00, (ph == -100) ? 10'b0101010100 : 10'b1010101011})
                    $display("FAIL blank_ctrl h=%0d: got %b %b %b", ph, sym_r, sym_g, sym_b);
                else n_pass++;
            end
            if (hs) begin
                hs_cnt++;
                if (first_hs == 9999) first_hs = int'(hpos);
                last_hs = int'(hpos);
            end
        end
        n_checks++;
        if ({hpos, vpos} !== {-12'sd138, -11'sd44})
            $display("FAIL line_wrap: got h=%0d v=%0d, expected -138 -44", hpos, vpos);
        else n_pass++;
        n_checks++;
        if (hs_cnt != 62 || first_hs != -122 || last_hs != -61)
            $display("FAIL hsync_window: got count=%0d first=%0d last=%0d, expected 62 -122 -61",
                     hs_cnt, first_hs, last_hs);
        else n_pass++;
    endtask

    task automatic test_vertical_timing();
        int eh, ev, vs_cnt, first_vs, last_vs;
        logic ede, ehs, evs, prev_vs;
        vs_cnt = 0;
        first_vs = 9999;
        last_vs = 9999;
        prev_vs = vs;
        while (t < 20 * HT) begin
            step_big();
            eh = m_h(t, HA, HBL);
            ev = m_v(t, HA, HBL, VA, VBL);
            ede = (eh >= 0 && ev >= 0);
            ehs = m_sync(eh, HBL, HF, HS);
            evs = m_sync(ev, VBL, VF, VS);
            n_checks++;
            if ({hpos, vpos, de, hs, vs} !== {12'(eh), 11'(ev), ede, ehs, evs})
                $display("FAIL vert_raster t=%0d: got h=%0d v=%0d de=%b hs=%b vs=%b, expected %0d %0d %b %b %b",
                         t, hpos, vpos, de, hs, vs, eh, ev, ede, ehs, evs);
            else n_pass++;
            n_checks++;
            if ({sym_r, sym_g, sym_b} !== {exp_r, exp_g, exp_b})
                $display("FAIL vert_symbols t=%0d: got %h %h %h, expected %h %h %h",
                         t, sym_r, sym_g, sym_b, exp_r, exp_g, exp_b);
            else n_pass++;
            if (vs !== prev_vs) begin
                n_checks++;
                if (hpos !== -12'sd138)
                    $display("FAIL vsync_edge: changed at h=%0d, expected -138", hpos);
                else n_pass++;
            end
            prev_vs = vs;
            if (vs) begin
                vs_cnt++;
                if (first_vs == 9999) first_vs = int'(vpos);
                last_vs = int'(vpos);
            end
        end
        n_checks++;
        if (vs_cnt != 6 * HT || first_vs != -36 || last_vs != -31)
            $display("FAIL vsync_window: got cycles=%0d first=%0d last=%0d, expected %0d -36 -31",
                     vs_cnt, first_vs, last_vs, 6 * HT);
        else n_pass++;
    endtask

    task automatic test_active_encoding();
        int eh, ev, ph, pv, de_cnt;
        logic ede, ehs, evs;
        logic [9:0] want;
        de_cnt = 0;
        while (t < 48 * HT) begin
            step_big();
            eh = m_h(t, HA, HBL);
            ev = m_v(t, HA, HBL, VA, VBL);
            ede = (eh >= 0 && ev >= 0);
            ehs = m_sync(eh, HBL, HF, HS);
            evs = m_sync(ev, VBL, VF, VS);
            n_checks++;
            if ({hpos, vpos, de, hs, vs} !== {12'(eh), 11'(ev), ede, ehs, evs})
                $display("FAIL act_raster t=%0d: got h=%0d v=%0d de=%b hs=%b vs=%b, expected %0d %0d %b %b %b",
                         t, hpos, vpos, de, hs, vs, eh, ev, ede, ehs, evs);
            else n_pass++;
            n_checks++;
            if ({sym_r, sym_g, sym_b} !== {exp_r, exp_g, exp_b})
                $display("FAIL act_symbols t=%0d: got %h %h %h, expected %h %h %h",
                         t, sym_r, sym_g, sym_b, exp_r, exp_g, exp_b);
            else n_pass++;
            if (de) de_cnt++;
            ph = m_h(t - 2, HA, HBL);
            pv = m_v(t - 2, HA, HBL, VA, VBL);
            if ((pv == 0 && ph >= 0 && ph <= 2) || (pv == 1 && ph == 0) || (pv == 2 && ph == 0)) begin
                if (pv == 1)                want = 10'h200;
                else if (pv == 0 && ph == 1) want = 10'h3FF;
                else                         want = 10'h100;
                n_checks++;
                if ({sym_r, sym_g, sym_b} !== {want, want, want})
                    $display("FAIL known_pixel (%0d,%0d): got %h %h %h, expected %h x3",
                             ph, pv, sym_r, sym_g, sym_b, want);
                else n_pass++;
            end
        end
        n_checks++;
        if (de_cnt != 3 * HA)
            $display("FAIL active_count: got %0d, expected %0d", de_cnt, 3 * HA);
        else n_pass++;
    endtask

    task automatic test_small_frame();
        int eh, ev, de_cnt, vs_cnt;
        logic ede, ehs, evs;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_s = 1'b0;
        ts = 0;
        de_cnt = 0;
        vs_cnt = 0;
        n_checks++;
        if ({s_hpos, s_vpos, s_de, s_hs, s_vs} !== {-12'sd9, -11'sd6, 1'b0, 1'b0, 1'b0})
            $display("FAIL small_reset: got h=%0d v=%0d de=%b hs=%b vs=%b, expected -9 -6 0 0 0",
                     s_hpos, s_vpos, s_de, s_hs, s_vs);
        else n_pass++;
        while (ts < 600) begin
            @(posedge clk);
            #1;
            ts++;
            eh = m_h(ts, SHA, SHBL);
            ev = m_v(ts, SHA, SHBL, SVA, SVBL);
            ede = (eh >= 0 && ev >= 0);
            ehs = m_sync(eh, SHBL, SHF, SHS);
            evs = m_sync(ev, SVBL, SVF, SVS);
            n_checks++;
            if ({s_hpos, s_vpos, s_de, s_hs, s_vs} !== {12'(eh), 11'(ev), ede, ehs, evs})
                $display("FAIL small_raster t=%0d: got h=%0d v=%0d de=%b hs=%b vs=%b, expected %0d %0d %b %b %b",
                         ts, s_hpos, s_vpos, s_de, s_hs, s_vs, eh, ev, ede, ehs, evs);
            else n_pass++;
            if (ts <= 300) begin
                if (s_de) de_cnt++;
                if (s_vs) vs_cnt++;
            end
            if (ts == 300 || ts == 600) begin
                n_checks++;
                if ({s_hpos, s_vpos} !== {-12'sd9, -11'sd6})
                    $display("FAIL small_frame_wrap t=%0d: got h=%0d v=%0d, expected -9 -6",
                             ts, s_hpos, s_vpos);
                else n_pass++;
            end
        end
        n_checks++;
        if (de_cnt != SHA * SVA || vs_cnt != SVS * (SHA + SHBL))
            $display("FAIL small_frame_counts: got de=%0d vs=%0d, expected %0d %0d",
                     de_cnt, vs_cnt, SHA * SVA, SVS * (SHA + SHBL));
        else n_pass++;
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        red   = 8'h00;
        green = 8'h00;
        blue  = 8'h00;
        test_reset();
        test_line_timing();
        test_vertical_timing();
        test_active_encoding();
        test_small_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
